// File: rtl/iodelay_tap_ctrl_if.sv
// Command channel into the IODELAY tap sequencer: a target tap or a
// static-delay reload request, moved over a valid/ready handshake.
interface iodelay_tap_ctrl_if #(
  parameter int TAP_W = 7
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [TAP_W-1:0] cmd_tap;

  modport master (output cmd_valid, output cmd_load, output cmd_tap, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_load, input cmd_tap, output cmd_ready);
endinterface

// File: rtl/iodelay_tap_ctrl.sv
// Steps a dynamic-mode IODELAY from its tracked tap to a commanded target
// using SETN/VALUE pulses with settle gaps, or reloads its static delay.
module iodelay_tap_ctrl #(
  parameter int TAP_W      = 7,
  parameter int MAX_TAP    = 127,
  parameter int STATIC_DLY = 0,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  iodelay_tap_ctrl_if.slave  cmd,
  output logic               dly_sdtap,
  output logic               dly_setn,
  output logic               dly_value,
  input  logic               dly_df,
  output logic [TAP_W-1:0]   cur_tap,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [TAP_W-1:0] STATIC_TAP  = TAP_W'(STATIC_DLY);
  localparam logic [TAP_W:0]   MAX_TAP_X   = (TAP_W + 1)'(MAX_TAP);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIR,
    PULSE_HI,
    PULSE_LO,
    SETTLE,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [TAP_W-1:0] target;
  logic             from_load;

  // All outputs are registered; each transition sets the values the next state presents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      target        <= '0;
      from_load     <= 1'b0;
      cur_tap       <= STATIC_TAP;
      cmd.cmd_ready <= 1'b0;
      dly_sdtap     <= 1'b0;
      dly_setn      <= 1'b0;
      dly_value     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd.cmd_valid && cmd.cmd_ready) begin
            cmd.cmd_ready <= 1'b0;
            busy          <= 1'b1;
            target        <= cmd.cmd_tap;
            from_load     <= cmd.cmd_load;
            if (cmd.cmd_load) begin
              state     <= LOAD;
              dly_sdtap <= 1'b1;
              cnt       <= PULSE_LAST;
            end else if ({1'b0, cmd.cmd_tap} > MAX_TAP_X) begin
              state <= DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (cmd.cmd_tap == cur_tap) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= DIR;
              dly_setn <= (cmd.cmd_tap < cur_tap);
            end
          end else begin
            cmd.cmd_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (cnt == '0) begin
            dly_sdtap <= 1'b0;
            cur_tap   <= STATIC_TAP;
            state     <= SETTLE;
            cnt       <= SETTLE_LAST;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIR: begin
          state     <= PULSE_HI;
          dly_value <= 1'b1;
          cnt       <= PULSE_LAST;
        end
        PULSE_HI: begin
          if (cnt == '0) begin
            dly_value <= 1'b0;
            state     <= PULSE_LO;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PULSE_LO: begin
          cur_tap <= dly_setn ? (cur_tap - 1'b1) : (cur_tap + 1'b1);
          state   <= SETTLE;
          cnt     <= SETTLE_LAST;
        end
        SETTLE: begin
          // A DF flag after a real step aborts even on the final settle cycle.
          if (!from_load && dly_df) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else if (cnt == '0) begin
            if (from_load || cur_tap == target) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= DIR;
              dly_setn <= (target < cur_tap);
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state         <= IDLE;
          busy          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
